// File: rtl/column_output_demux_pkg.sv
// col_demux_pkg: shared types and helpers for column_output_demux.
//   state_e  : slot FSM states (IDLE, SLOT_A, SLOT_B)
//   inf_time : all-ones "never fired" time code for a given time width
package col_demux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLOT_A = 2'd1,
    SLOT_B = 2'd2
  } state_e;

  // Returned as 32 bits; callers keep the low tw bits.
  function automatic logic [31:0] inf_time(input int unsigned tw);
    if (tw >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << tw) - 32'd1;
  endfunction

endpackage

// File: rtl/first_spike_capture.sv
// first_spike_capture: per-slot bank recording the first spike time of each of Q neurons.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : reset the bank to time INF / not fired (slot opening cycle)
//   en         : slot is active this cycle; spikes are captured at time t
//   t          : current slot time
//   spikes     : Q one-cycle spike pulses
//   times      : captured times, neuron i at [i*TW +: TW] (INF if not fired)
//   fired      : neuron has spiked in this slot
module first_spike_capture
  import col_demux_pkg::*;
#(
  parameter int unsigned Q  = 8,
  parameter int unsigned TW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            en,
  input  logic [TW-1:0]   t,
  input  logic [Q-1:0]    spikes,
  output logic [Q*TW-1:0] times,
  output logic [Q-1:0]    fired
);

  localparam logic [31:0]   InfFull = inf_time(TW);
  localparam logic [TW-1:0] Inf     = InfFull[TW-1:0];

  logic [Q*TW-1:0] times_q, times_d;
  logic [Q-1:0]    fired_q, fired_d;

  always_comb begin
    times_d = times_q;
    fired_d = fired_q;
    // Clear first so a spike on the opening cycle lands in the fresh bank at t = 0.
    if (clear) begin
      times_d = {Q{Inf}};
      fired_d = '0;
    end
    if (en) begin
      for (int i = 0; i < Q; i++) begin
        if (spikes[i] && !fired_d[i]) begin
          times_d[i*TW +: TW] = t;
          fired_d[i]          = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      times_q <= {Q{Inf}};
      fired_q <= '0;
    end else begin
      times_q <= times_d;
      fired_q <= fired_d;
    end
  end

  assign times = times_q;
  assign fired = fired_q;

endmodule

// File: rtl/column_output_demux.sv
// column_output_demux: splits multiplexed column spikes into slot-A / slot-B first-spike
// times per gamma cycle and publishes both through a valid/ready output register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   grst              : gamma level (high = slot A, low = slot B)
//   col_spike         : Q one-cycle column spikes
//   out_ready         : consumer accepts result
//   out_valid         : output registers hold a published result
//   a_time, b_time    : first-spike times, neuron i at [i*TW +: TW]
//   a_fired, b_fired  : neuron spiked in slot
//   overflow          : one-cycle pulse when a new result is dropped
//   ovf_count         : saturating overflow count (only with COLUMN_DEMUX_OVF_CNT_EN)
module column_output_demux
  import col_demux_pkg::*;
#(
  parameter int unsigned Q           = 8,
  parameter int unsigned SLOT_CYCLES = 8,
  localparam int unsigned TW         = $clog2(SLOT_CYCLES) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            grst,
  input  logic [Q-1:0]    col_spike,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [Q*TW-1:0] a_time,
  output logic [Q*TW-1:0] b_time,
  output logic [Q-1:0]    a_fired,
  output logic [Q-1:0]    b_fired,
  output logic            overflow
`ifdef COLUMN_DEMUX_OVF_CNT_EN
  ,
  output logic [7:0]      ovf_count
`endif
);

  localparam logic [TW-1:0] TMax = TW'(SLOT_CYCLES - 1);

  state_e          state_q, state_d;
  logic            grst_q;
  logic [TW-1:0]   t_q, t_d, t_now;
  logic            rise, fall, open_a, open_b, publish;

  logic [Q*TW-1:0] bank_a_times, bank_b_times;
  logic [Q-1:0]    bank_a_fired, bank_b_fired;

  logic            out_valid_q, out_valid_d;
  logic            overflow_q, overflow_d;
  logic [Q*TW-1:0] a_time_q, a_time_d, b_time_q, b_time_d;
  logic [Q-1:0]    a_fired_q, a_fired_d, b_fired_q, b_fired_d;

  always_comb begin
    rise = grst & ~grst_q;
    fall = ~grst & grst_q;

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (rise) state_d = SLOT_A;
      SLOT_A:  if (fall) state_d = SLOT_B;
      SLOT_B:  if (rise) state_d = SLOT_A;
      default: state_d = IDLE;
    endcase

    open_a  = (state_d == SLOT_A) && (state_q != SLOT_A);
    open_b  = (state_d == SLOT_B) && (state_q != SLOT_B);
    publish = (state_q == SLOT_B) && (state_d == SLOT_A);

    // The edge cycle that opens a slot is time 0 of that slot.
    t_now = (open_a || open_b) ? '0 : t_q;
    if (state_d == IDLE) begin
      t_d = '0;
    end else if (t_now == TMax) begin
      t_d = TMax;
    end else begin
      t_d = t_now + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grst_q  <= 1'b0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      grst_q  <= grst;
      t_q     <= t_d;
    end
  end

  // Enables follow the slot active this cycle, so edge-cycle spikes go to the new slot.
  first_spike_capture #(
    .Q  (Q),
    .TW (TW)
  ) u_bank_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (open_a),
    .en     (state_d == SLOT_A),
    .t      (t_now),
    .spikes (col_spike),
    .times  (bank_a_times),
    .fired  (bank_a_fired)
  );

  first_spike_capture #(
    .Q  (Q),
    .TW (TW)
  ) u_bank_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (open_b),
    .en     (state_d == SLOT_B),
    .t      (t_now),
    .spikes (col_spike),
    .times  (bank_b_times),
    .fired  (bank_b_fired)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    overflow_d  = 1'b0;
    a_time_d    = a_time_q;
    b_time_d    = b_time_q;
    a_fired_d   = a_fired_q;
    b_fired_d   = b_fired_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (publish) begin
      // Bank outputs are registered, so they still show the gamma just finished.
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        a_time_d    = bank_a_times;
        b_time_d    = bank_b_times;
        a_fired_d   = bank_a_fired;
        b_fired_d   = bank_b_fired;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      a_time_q    <= '0;
      b_time_q    <= '0;
      a_fired_q   <= '0;
      b_fired_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      a_time_q    <= a_time_d;
      b_time_q    <= b_time_d;
      a_fired_q   <= a_fired_d;
      b_fired_q   <= b_fired_d;
    end
  end

  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign a_time    = a_time_q;
  assign b_time    = b_time_q;
  assign a_fired   = a_fired_q;
  assign b_fired   = b_fired_q;

`ifdef COLUMN_DEMUX_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (overflow_d && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_q <= 8'd0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_column_output_demux.sv
// tb_column_output_demux: scoreboard bench for column_output_demux (Q=4, SLOT_CYCLES=8).
// Stimulus pushes hand-computed gamma results; a negedge monitor pops and compares on
// every accepted result and checks held results while the consumer stalls.
module tb_column_output_demux;

  localparam int unsigned Q  = 4;
  localparam int unsigned SC = 8;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        grst      = 1'b0;
  logic [3:0]  col_spike = 4'hF;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [15:0] a_time, b_time;
  logic [3:0]  a_fired, b_fired;
  logic        overflow;
`ifdef COLUMN_DEMUX_OVF_CNT_EN
  logic [7:0]  ovf_count;
`endif

  column_output_demux #(
    .Q           (Q),
    .SLOT_CYCLES (SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .grst      (grst),
    .col_spike (col_spike),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .a_time    (a_time),
    .b_time    (b_time),
    .a_fired   (a_fired),
    .b_fired   (b_fired),
    .overflow  (overflow)
`ifdef COLUMN_DEMUX_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a_t;
    logic [15:0] b_t;
    logic [3:0]  a_f;
    logic [3:0]  b_f;
  } res_t;

  res_t       exp_q[$];
  res_t       mon_e;
  int         checks       = 0;
  int         failures     = 0;
  int         ovf_seen     = 0;
  int         valid_cycles = 0;
  int         valid_mark   = 0;
  logic [3:0] sp_tab [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cmp_res(input string name, input res_t e);
    chk({name, "_a_time"},  {16'h0, a_time},  {16'h0, e.a_t});
    chk({name, "_b_time"},  {16'h0, b_time},  {16'h0, e.b_t});
    chk({name, "_a_fired"}, {28'h0, a_fired}, {28'h0, e.a_f});
    chk({name, "_b_fired"}, {28'h0, b_fired}, {28'h0, e.b_f});
  endtask

  // Monitor: pops on handshake, checks held contents while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overflow) ovf_seen++;
      if (out_valid) valid_cycles++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=valid required=no_result");
        end else begin
          mon_e = exp_q.pop_front();
          cmp_res("accept", mon_e);
        end
      end else if (out_valid && !out_ready && exp_q.size() != 0) begin
        cmp_res("held", exp_q[0]);
      end
    end
  end

  // Drive one slot: cycle i carries sp_tab[i]; cycle 0 is the grst edge (t = 0).
  task automatic slot(input logic g, input int len);
    for (int i = 0; i < len; i++) begin
      grst      = g;
      col_spike = sp_tab[i];
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 16; i++) sp_tab[i] = 4'h0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) sp_tab[i] = 4'h0;

    // Reset with all spikes asserted.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_overflow",  {31'h0, overflow},  32'h0);
    chk("rst_a_time",    {16'h0, a_time},    32'h0);
    chk("rst_b_time",    {16'h0, b_time},    32'h0);
    chk("rst_a_fired",   {28'h0, a_fired},   32'h0);
    chk("rst_b_fired",   {28'h0, b_fired},   32'h0);
`ifdef COLUMN_DEMUX_OVF_CNT_EN
    chk("rst_ovf_count", {24'h0, ovf_count}, 32'h0);
`endif
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle: spikes before the first rise are ignored.
    repeat (4) begin
      col_spike = 4'hF;
      @(posedge clk);
      #1;
    end
    col_spike = 4'h0;
    chk("idle_no_valid", valid_cycles, 0);

    // Gamma 1: neuron 2 at t=3 in A, t=5 in B.
    exp_q.push_back('{a_t: 16'hF3FF, b_t: 16'hF5FF, a_f: 4'b0100, b_f: 4'b0100});
    sp_tab[3] = 4'b0100;
    slot(1'b1, 8);
    sp_tab[5] = 4'b0100;
    slot(1'b0, 8);

    // Gamma 2: neuron 3 on the rise cycle (A t=0, not in gamma 1 B); neuron 0 at 1,2,6;
    // neuron 1 late in a long A slot (saturates at 7); B: neuron 0 on fall cycle, n1 at 7.
    exp_q.push_back('{a_t: 16'h0F71, b_t: 16'hFF70, a_f: 4'b1011, b_f: 4'b0011});
    sp_tab[0]  = 4'b1000;
    sp_tab[1]  = 4'b0001;
    sp_tab[2]  = 4'b0001;
    sp_tab[6]  = 4'b0001;
    sp_tab[10] = 4'b0010;
    slot(1'b1, 12);
    sp_tab[0] = 4'b0001;
    sp_tab[7] = 4'b0010;
    slot(1'b0, 8);

    // Gamma 3: published while consumer is stalled, then held.
    exp_q.push_back('{a_t: 16'hFF2F, b_t: 16'h4FFF, a_f: 4'b0010, b_f: 4'b1000});
    sp_tab[2] = 4'b0010;
    slot(1'b1, 8);
    out_ready = 1'b0;
    sp_tab[4] = 4'b1000;
    slot(1'b0, 8);

    // Gamma 4: dropped on publish (overflow).
    sp_tab[5] = 4'b0001;
    slot(1'b1, 8);
    sp_tab[1] = 4'b0100;
    slot(1'b0, 8);

    // Gamma 5: publish coincides with the handshake of gamma 3.
    exp_q.push_back('{a_t: 16'hFF4F, b_t: 16'hFFF6, a_f: 4'b0010, b_f: 4'b0001});
    sp_tab[4] = 4'b0010;
    slot(1'b1, 8);
    chk("ovf_once", ovf_seen, 1);
`ifdef COLUMN_DEMUX_OVF_CNT_EN
    chk("ovf_count_one", {24'h0, ovf_count}, 32'h1);
`endif
    sp_tab[6] = 4'b0001;
    slot(1'b0, 8);
    out_ready = 1'b1;
    sp_tab[3] = 4'b0100;
    slot(1'b1, 8);
    chk("ovf_no_drop_on_accept", ovf_seen, 1);

    // Reset mid slot B: outputs clear at once, partial captures lost.
    sp_tab[1] = 4'b1000;
    slot(1'b0, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_a_time",    {16'h0, a_time},    32'h0);
    chk("midrst_b_time",    {16'h0, b_time},    32'h0);
    chk("midrst_a_fired",   {28'h0, a_fired},   32'h0);
    chk("midrst_b_fired",   {28'h0, b_fired},   32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    valid_mark = valid_cycles;

    // Gamma 7: full A+B after reset, all neurons at t=2 in A, none in B.
    exp_q.push_back('{a_t: 16'h2222, b_t: 16'hFFFF, a_f: 4'b1111, b_f: 4'b0000});
    sp_tab[2] = 4'b1111;
    slot(1'b1, 8);
    slot(1'b0, 8);
    chk("no_valid_before_full_gamma", valid_cycles - valid_mark, 0);
    slot(1'b1, 4);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("queue_drained", exp_q.size(), 0);
    chk("ovf_total", ovf_seen, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/column_output_demux.md
COLUMN_OUTPUT_DEMUX -- requirements
Module: column_output_demux

Interface
REQ-001 SHALL have parameter Q, default 8: number of column output neurons.
REQ-002 SHALL have parameter SLOT_CYCLES, default 8: clk cycles in one half-gamma slot.
REQ-003 SHALL have derived localparam TW = $clog2(SLOT_CYCLES)+1: spike-time width; INF = all-ones of TW.
REQ-004 SHALL have port clk  in  1: single clock; all logic on posedge.
REQ-005 SHALL have port rst_n  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have port grst  in  1: gamma level, synchronous to clk; high = slot A (input-1 replay), low = slot B (input-2 replay).
REQ-007 SHALL have port col_spike  in  Q: multiplexed column output spikes, 1-cycle pulses.
REQ-008 SHALL have port out_ready  in  1: consumer accepts result.
REQ-009 SHALL have port out_valid  out  1: result registers hold a published gamma result.
REQ-010 SHALL have port a_time  out  Q*TW: slot-A first-spike times, neuron i at [i*TW +: TW].
REQ-011 SHALL have port b_time  out  Q*TW: slot-B first-spike times, same packing.
REQ-012 SHALL have port a_fired, b_fired  out  Q: neuron spiked in slot.
REQ-013 SHALL have port overflow  out  1: one-cycle pulse when a result is dropped.

Function
REQ-014 SHALL register grst into grst_q; rise = grst & ~grst_q, fall = ~grst & grst_q, acted on in the same cycle.
REQ-015 SHALL implement FSM IDLE, SLOT_A, SLOT_B: IDLE->SLOT_A on rise; SLOT_A->SLOT_B on fall; SLOT_B->SLOT_A on rise; all other edges ignored (fall in IDLE ignored).
REQ-016 SHALL keep slot counter t = 0 on the edge cycle that opens a slot, +1 per cycle, saturating at SLOT_CYCLES-1.
REQ-017 SHALL capture, per neuron per slot, only the first col_spike: time = t, fired = 1; later spikes in the same slot ignored.
REQ-018 SHALL attribute a spike on an edge cycle to the newly opened slot with time 0.
REQ-019 SHALL clear a slot's capture bank (time = INF, fired = 0) on the cycle that opens it.
REQ-020 SHALL publish on the SLOT_B->SLOT_A rise: both banks (contents up to the previous cycle) load into output registers; out_valid = 1 from the next cycle.
REQ-021 SHALL complete handshake when out_valid & out_ready; out_valid falls next cycle unless a publish coincides.
REQ-022 SHALL, on publish with out_valid & out_ready the same cycle, load the new result with no overflow.
REQ-023 SHALL, on publish with out_valid & ~out_ready, keep the held result unchanged, discard the new one, and pulse overflow for 1 cycle.
REQ-024 SHALL hold all outputs stable while out_valid & ~out_ready.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force FSM = IDLE, t = 0, grst_q = 0, banks = INF/0, out_valid = 0, overflow = 0, a_time = b_time = 0, a_fired = b_fired = 0.
REQ-026 SHALL, after reset mid-slot, require a full SLOT_A + SLOT_B before the next publish; partial captures are lost.

Configuration
REQ-027 SHALL, with COLUMN_DEMUX_OVF_CNT_EN defined, add output ovf_count [7:0]: saturating count of overflow pulses, cleared by reset.
REQ-028 SHALL, without COLUMN_DEMUX_OVF_CNT_EN, omit port ovf_count and counter; all other behaviour identical.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, SLOT_A, SLOT_B) and an INF-time helper function in shared package col_demux_pkg.
REQ-030 SHALL implement the per-slot Q-neuron first-spike bank as sub-module first_spike_capture (inputs clear, en, t, spikes; outputs times, fired), instantiated twice.

Verification (Q=4, SLOT_CYCLES=8, TW=4, INF=4'hF)
REQ-031 SHALL cover: rst_n low with col_spike = 4'hF -> out_valid = 0, all outputs 0; spikes ignored until first grst rise.
REQ-032 SHALL cover: neuron 2 spikes at t=3 in A and t=5 in B -> after publish a_time[2] = 3, b_time[2] = 5, a_fired = b_fired = 4'b0100, other times 4'hF.
REQ-033 SHALL cover: neuron 0 spikes at t=1, 2, 6 in A -> a_time[0] = 1.
REQ-034 SHALL cover: spike on the exact grst-rise cycle -> recorded as slot A time 0, absent from the published slot B.
REQ-035 SHALL cover: out_ready = 0 across two publishes -> first result held bit-exact; overflow pulses once; ovf_count = 1 with macro.
REQ-036 SHALL cover: rst_n pulse mid SLOT_B -> outputs clear immediately; next out_valid only after one full A+B sequence.
